instr_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory interface in the IF stage.
- Owns the PC and drives the word address to the combinational instruction memory.
- Captures the returned word into the IF/ID pipeline register and hands it to decode with a valid/ready handshake.
- Handles execute-stage redirects, decode stalls, halt-on-zero-word termination and out-of-range fetch faults.

---
 rtl/instr_fetch_unit_if.sv | 26 ++
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 tb/tb_instr_fetch_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// IF-stage bus bundle: instruction-memory port, IF/ID handshake, redirect and status.
// The master modport is the fetch unit; the slave modport is memory/decode/execute.
interface instr_fetch_unit_if;
  logic        fetch_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        id_ready;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  modport master (
    input  fetch_en, mem_data, id_ready, ex_redirect, ex_target,
    output mem_addr, ifid_valid, ifid_instr, ifid_npc, halted, fault, fetch_count
  );

  modport slave (
    output fetch_en, mem_data, id_ready, ex_redirect, ex_target,
    input  mem_addr, ifid_valid, ifid_instr, ifid_npc, halted, fault, fetch_count
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC owner, drives combinational imem, fills IF/ID register; 1-cycle PC->ifid latency.
// Backpressure: valid && !id_ready freezes everything except a redirect, which squashes the held entry.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'd0,
  parameter int unsigned MEM_DEPTH    = 128,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);

  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    npc_d    = npc_q;
    count_d  = count_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    fault_d  = fault_q;

    unique case (state_q)
      IDLE: begin
        if (bus.fetch_en) state_d = RUN;
      end

      RUN: begin
        // Rule order matters: redirect > stall > fetch disabled > range fault > zero-word halt.
        if (bus.ex_redirect) begin
          pc_d    = bus.ex_target;
          valid_d = 1'b0;
        end else if (valid_q && !bus.id_ready) begin
          // stall: hold everything
        end else if (!bus.fetch_en) begin
          if (bus.id_ready) valid_d = 1'b0;
        end else if (pc_q >= DEPTH) begin
          state_d  = HALT;
          halted_d = 1'b1;
          fault_d  = 1'b1;
          valid_d  = 1'b0;
        end else if (HALT_ON_ZERO && (bus.mem_data == 32'd0)) begin
          state_d  = HALT;
          halted_d = 1'b1;
          valid_d  = 1'b0;
        end else begin
          instr_d = bus.mem_data;
          npc_d   = pc_q + 32'd1;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd1;
          count_d = count_q + 32'd1;
        end
      end

      HALT: begin
        if (bus.ex_redirect) begin
          pc_d     = bus.ex_target;
          state_d  = RUN;
          halted_d = 1'b0;
          fault_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      npc_q    <= 32'd0;
      count_q  <= 32'd0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      npc_q    <= npc_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.mem_addr    = pc_q;
  assign bus.ifid_valid  = valid_q;
  assign bus.ifid_instr  = instr_q;
  assign bus.ifid_npc    = npc_q;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: preloaded program, stall, redirect, fault and async reset.
module tb_instr_fetch_unit;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [31:0] mem [0:127];
  logic [31:0] exp_instr [0:8];

  instr_fetch_unit_if ifc ();

  instr_fetch_unit #(
    .RESET_PC    (32'd0),
    .MEM_DEPTH   (128),
    .HALT_ON_ZERO(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  // Out-of-range reads return a nonzero pattern so a missed range check would deliver it.
  assign ifc.mem_data = (ifc.mem_addr < 32'd128) ? mem[ifc.mem_addr[6:0]] : 32'hFFFF_FFFF;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    mem[0] = 32'h002300AA; mem[1] = 32'h10654321; mem[2] = 32'h00100022;
    mem[3] = 32'h8C123456; mem[4] = 32'h8F123456; mem[5] = 32'hAD654321;
    mem[6] = 32'h13012345; mem[7] = 32'hAC654321; mem[8] = 32'h12012345;
    mem[9] = 32'h00000000;
    exp_instr[0] = 32'h002300AA; exp_instr[1] = 32'h10654321; exp_instr[2] = 32'h00100022;
    exp_instr[3] = 32'h8C123456; exp_instr[4] = 32'h8F123456; exp_instr[5] = 32'hAD654321;
    exp_instr[6] = 32'h13012345; exp_instr[7] = 32'hAC654321; exp_instr[8] = 32'h12012345;

    rst             = 1'b0;
    ifc.fetch_en    = 1'b0;
    ifc.id_ready    = 1'b1;
    ifc.ex_redirect = 1'b0;
    ifc.ex_target   = 32'd0;
    #1 rst = 1'b1;
    #1;
    chk("rst_addr",   ifc.mem_addr,    32'd0);
    chk("rst_valid",  ifc.ifid_valid,  32'd0);
    chk("rst_instr",  ifc.ifid_instr,  32'd0);
    chk("rst_npc",    ifc.ifid_npc,    32'd0);
    chk("rst_halted", ifc.halted,      32'd0);
    chk("rst_fault",  ifc.fault,       32'd0);
    chk("rst_count",  ifc.fetch_count, 32'd0);

    // Straight-line run to the zero word at address 9
    step();
    rst = 1'b0;
    ifc.fetch_en = 1'b1;
    step();
    chk("idle_to_run_valid", ifc.ifid_valid, 32'd0);
    chk("idle_to_run_addr",  ifc.mem_addr,   32'd0);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("run_valid", ifc.ifid_valid, 32'd1);
      chk("run_instr", ifc.ifid_instr, exp_instr[i]);
      chk("run_npc",   ifc.ifid_npc,   32'(i + 1));
    end
    step();
    chk("zero_halted", ifc.halted,      32'd1);
    chk("zero_fault",  ifc.fault,       32'd0);
    chk("zero_addr",   ifc.mem_addr,    32'd9);
    chk("zero_count",  ifc.fetch_count, 32'd9);
    chk("zero_valid",  ifc.ifid_valid,  32'd0);
    step();
    chk("halt_hold_addr", ifc.mem_addr, 32'd9);

    // Stall after first delivery
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
    chk("restart_run_valid", ifc.ifid_valid, 32'd0);
    step();
    chk("first_instr", ifc.ifid_instr, 32'h002300AA);
    ifc.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_instr", ifc.ifid_instr,  32'h002300AA);
      chk("stall_valid", ifc.ifid_valid,  32'd1);
      chk("stall_addr",  ifc.mem_addr,    32'd1);
      chk("stall_count", ifc.fetch_count, 32'd1);
    end
    ifc.id_ready = 1'b1;
    step();
    chk("unstall_instr", ifc.ifid_instr,  32'h10654321);
    chk("unstall_npc",   ifc.ifid_npc,    32'd2);
    chk("unstall_count", ifc.fetch_count, 32'd2);

    // Redirect while a word is stalled in IF/ID
    ifc.ex_redirect = 1'b1;
    ifc.ex_target   = 32'd0;
    step();
    ifc.ex_redirect = 1'b0;
    ifc.id_ready    = 1'b0;
    step();
    chk("restall_instr", ifc.ifid_instr, 32'h002300AA);
    chk("restall_valid", ifc.ifid_valid, 32'd1);
    ifc.ex_redirect = 1'b1;
    ifc.ex_target   = 32'd5;
    step();
    chk("redir_valid", ifc.ifid_valid, 32'd0);
    chk("redir_addr",  ifc.mem_addr,   32'd5);
    ifc.ex_redirect = 1'b0;
    ifc.id_ready    = 1'b1;
    step();
    chk("redir_instr", ifc.ifid_instr,  32'hAD654321);
    chk("redir_npc",   ifc.ifid_npc,    32'd6);
    chk("redir_count", ifc.fetch_count, 32'd4);

    // Out-of-range fault: redirect loads PC, range check trips on the fetch edge
    ifc.ex_redirect = 1'b1;
    ifc.ex_target   = 32'd128;
    step();
    ifc.ex_redirect = 1'b0;
    chk("oor_addr",      ifc.mem_addr,   32'd128);
    chk("oor_valid_pre", ifc.ifid_valid, 32'd0);
    step();
    chk("oor_halted", ifc.halted,      32'd1);
    chk("oor_fault",  ifc.fault,       32'd1);
    chk("oor_valid",  ifc.ifid_valid,  32'd0);
    chk("oor_count",  ifc.fetch_count, 32'd4);
    ifc.ex_redirect = 1'b1;
    ifc.ex_target   = 32'd2;
    step();
    ifc.ex_redirect = 1'b0;
    chk("recover_halted", ifc.halted,   32'd0);
    chk("recover_fault",  ifc.fault,    32'd0);
    chk("recover_addr",   ifc.mem_addr, 32'd2);
    step();
    chk("recover_instr", ifc.ifid_instr,  32'h00100022);
    chk("recover_npc",   ifc.ifid_npc,    32'd3);
    chk("recover_count", ifc.fetch_count, 32'd5);

    // fetch_en low in RUN: PC holds and the consumed entry drains
    ifc.fetch_en = 1'b0;
    step();
    chk("noen_valid", ifc.ifid_valid, 32'd0);
    chk("noen_addr",  ifc.mem_addr,   32'd3);
    ifc.fetch_en = 1'b1;
    step();
    chk("reen_instr", ifc.ifid_instr, 32'h8C123456);
    chk("reen_addr",  ifc.mem_addr,   32'd4);

    // Async reset between edges at PC = 4
    #3;
    ifc.fetch_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_addr",  ifc.mem_addr,    32'd0);
    chk("arst_valid", ifc.ifid_valid,  32'd0);
    chk("arst_count", ifc.fetch_count, 32'd0);
    chk("arst_instr", ifc.ifid_instr,  32'd0);
    rst = 1'b0;
    step();
    step();
    chk("idle_hold_valid", ifc.ifid_valid,  32'd0);
    chk("idle_hold_count", ifc.fetch_count, 32'd0);
    ifc.fetch_en = 1'b1;
    step();
    chk("idle_exit_valid", ifc.ifid_valid, 32'd0);
    step();
    chk("post_rst_instr", ifc.ifid_instr,  32'h002300AA);
    chk("post_rst_count", ifc.fetch_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
